// File: rtl/edge_pe.sv
// Edge processing element: fetches a node's neighbor list, accumulates the neighbors' feature
// vectors lane-wise and writes the saturated result beats back. Define EDGE_WEIGHT_EN to weight products.
module edge_pe #(
  parameter int NODE_ID_W = 7,
  parameter int FV_W      = 8,
  parameter int LANES     = 2,
  parameter int MAX_BEATS = 4,
  parameter int MAX_NBR   = 7,
  parameter int ACC_W     = 16,
  parameter int REPLAY_W  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       task_valid,
  input  logic [NODE_ID_W+6:0]       task_packet,
  input  logic                       fv_sos,
  input  logic                       fv_eos,
  input  logic [LANES*FV_W-1:0]      fv_data,
  input  logic [LANES*FV_W-1:0]      out_sram_data,
  input  logic                       nid_sos,
  input  logic                       nid_eos,
  input  logic [1:0]                 nid_num,
  input  logic [2*NODE_ID_W-1:0]     nid_ids,
  input  logic                       bus_grant,
  input  logic [REPLAY_W-1:0]        cur_replay_iter,
  input  logic                       wb_grant,
  output logic                       bus_req,
  output logic [NODE_ID_W:0]         bus_req_pkt,
  output logic                       pe_idle,
  output logic                       task_done,
  output logic                       wb_req,
  output logic                       bank_valid,
  output logic [NODE_ID_W-1:0]       bank_node,
  output logic [1:0]                 bank_beat,
  output logic [REPLAY_W-1:0]        bank_iter,
  output logic [LANES*FV_W-1:0]      bank_data
);
  localparam int BEAT_W = 2;
  localparam int NBR_N  = MAX_NBR + 1;
  localparam logic [2:0]       MB   = 3'(MAX_BEATS);
  localparam logic [ACC_W-1:0] SATV = ACC_W'((1 << FV_W) - 1);

  typedef enum logic [2:0] {IDLE, REQ_NID, WAIT_NID, REQ_FV, RECV_FV, WB_REQ, WB} state_t;
  state_t r_state, w_nxt;

  logic [2:0]                                r_cnt, r_k, r_beat, r_len;
  logic [NODE_ID_W-1:0]                      r_node;
  logic [NBR_N-1:0][NODE_ID_W-1:0]           r_nbr;
  logic [3:0]                                r_nidx;
  logic                                      r_nid_mid, r_fv_mid, r_done;
  logic [MAX_BEATS-1:0][LANES-1:0][ACC_W-1:0] r_acc;
  logic [BEAT_W-1:0]                         r_wb_b;
  logic [LANES-1:0][ACC_W-1:0]               w_prod;
  logic                                      w_fv_vld, w_nid_vld, w_last, w_unused;
  logic [2:0]                                w_b, w_k_nxt;

`ifdef EDGE_WEIGHT_EN
  logic [3:0] r_weight;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_weight <= '0;
    else if (r_state == IDLE && task_valid) r_weight <= task_packet[NODE_ID_W+6:NODE_ID_W+3];
  always_comb
    for (int l = 0; l < LANES; l++)
      w_prod[l] = ACC_W'(fv_data[l*FV_W +: FV_W]) * ACC_W'(r_weight);
  assign w_unused = ^out_sram_data;
`else
  always_comb
    for (int l = 0; l < LANES; l++)
      w_prod[l] = ACC_W'(fv_data[l*FV_W +: FV_W]);
  assign w_unused = ^{out_sram_data, task_packet[NODE_ID_W+6:NODE_ID_W+3]};
`endif

  // Mid-stream beats carry neither flag, so the stream position is tracked locally.
  assign w_fv_vld  = (r_state == RECV_FV)  && (fv_sos  || fv_eos  || r_fv_mid);
  assign w_nid_vld = (r_state == WAIT_NID) && (nid_sos || nid_eos || r_nid_mid);
  assign w_b       = fv_sos ? 3'd0 : r_beat;
  assign w_k_nxt   = r_k + 3'd1;

  always_comb begin
    w_nxt       = r_state;
    bus_req     = 1'b0;
    bus_req_pkt = '0;
    wb_req      = 1'b0;
    bank_valid  = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE:     if (task_valid)
                  w_nxt = (task_packet[NODE_ID_W+2:NODE_ID_W] == 3'd0) ? WB_REQ : REQ_NID;
      REQ_NID:  begin
                  bus_req     = 1'b1;
                  bus_req_pkt = {1'b0, r_node};
                  if (bus_grant) w_nxt = WAIT_NID;
                end
      WAIT_NID: if (w_nid_vld && nid_eos) w_nxt = REQ_FV;
      REQ_FV:   begin
                  bus_req     = 1'b1;
                  bus_req_pkt = {1'b1, r_nbr[r_k]};
                  if (bus_grant) w_nxt = RECV_FV;
                end
      RECV_FV:  if (w_fv_vld && fv_eos) w_nxt = (w_k_nxt < r_cnt) ? REQ_FV : WB_REQ;
      WB_REQ:   begin
                  wb_req = 1'b1;
                  if (wb_grant) w_nxt = WB;
                end
      WB:       begin
                  bank_valid = (r_len != 3'd0);
                  w_last     = (r_len == 3'd0) || (r_wb_b == BEAT_W'(r_len - 3'd1));
                  if (w_last) w_nxt = IDLE;
                end
      default:  w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_node    <= '0;
      r_nbr     <= '0;
      r_nidx    <= '0;
      r_nid_mid <= 1'b0;
      r_fv_mid  <= 1'b0;
      r_k       <= '0;
      r_beat    <= '0;
      r_len     <= '0;
      r_acc     <= '0;
      r_wb_b    <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_done  <= (r_state == WB) && w_last;
      if (r_state == IDLE && task_valid) begin
        r_cnt     <= task_packet[NODE_ID_W+2:NODE_ID_W];
        r_node    <= task_packet[NODE_ID_W-1:0];
        r_nidx    <= '0;
        r_k       <= '0;
        r_len     <= '0;
        r_nid_mid <= 1'b0;
        r_fv_mid  <= 1'b0;
      end
      if (w_nid_vld) begin
        r_nid_mid <= !nid_eos;
        if (nid_num != 2'd0 && r_nidx < 4'(NBR_N))
          r_nbr[r_nidx[2:0]] <= nid_ids[2*NODE_ID_W-1:NODE_ID_W];
        if (nid_num == 2'd2 && r_nidx + 4'd1 < 4'(NBR_N))
          r_nbr[3'(r_nidx + 4'd1)] <= nid_ids[NODE_ID_W-1:0];
        r_nidx <= r_nidx + 4'(nid_num);
      end
      // Beats past MAX_BEATS are counted but never accumulated.
      if (w_fv_vld) begin
        r_fv_mid <= !fv_eos;
        r_beat   <= (w_b == MB) ? w_b : w_b + 3'd1;
        if (w_b < MB)
          for (int l = 0; l < LANES; l++)
            r_acc[w_b[BEAT_W-1:0]][l] <= r_acc[w_b[BEAT_W-1:0]][l] + w_prod[l];
        if (fv_eos) begin
          r_k <= w_k_nxt;
          if (r_k == 3'd0) r_len <= (w_b == MB) ? MB : w_b + 3'd1;
        end
      end
      if (bank_valid) r_wb_b <= r_wb_b + BEAT_W'(1);
      if (r_state == WB && w_last) begin
        r_acc  <= '0;
        r_wb_b <= '0;
      end
    end
  end

  assign pe_idle   = (r_state == IDLE);
  assign task_done = r_done;
  assign bank_node = bank_valid ? r_node : '0;
  assign bank_beat = bank_valid ? r_wb_b : '0;
  assign bank_iter = bank_valid ? cur_replay_iter : '0;

  always_comb begin
    bank_data = '0;
    if (bank_valid)
      for (int l = 0; l < LANES; l++)
        bank_data[l*FV_W +: FV_W] = (r_acc[r_wb_b][l] > SATV) ? {FV_W{1'b1}}
                                                              : r_acc[r_wb_b][l][FV_W-1:0];
  end
endmodule

// File: tb/tb_edge_pe.sv
// Directed bench for edge_pe; expected beats are computed from the stimulus tables.
module tb_edge_pe;
  logic        clk = 1'b0, reset = 1'b0;
  logic        task_valid = 0, fv_sos = 0, fv_eos = 0, nid_sos = 0, nid_eos = 0;
  logic        bus_grant = 0, wb_grant = 0;
  logic [13:0] task_packet = '0, nid_ids = '0;
  logic [15:0] fv_data = '0, out_sram_data = '0, bank_data;
  logic [1:0]  nid_num = '0, cur_replay_iter = '0, bank_beat, bank_iter;
  logic        bus_req, pe_idle, task_done, wb_req, bank_valid;
  logic [7:0]  bus_req_pkt;
  logic [6:0]  bank_node;

  int n_chk = 0, n_fail = 0;
  logic [15:0] fv_tab[8][4];
  int          fv_n[8];
  int          ids[8];

  edge_pe dut (
    .clk(clk), .reset(reset), .task_valid(task_valid), .task_packet(task_packet),
    .fv_sos(fv_sos), .fv_eos(fv_eos), .fv_data(fv_data), .out_sram_data(out_sram_data),
    .nid_sos(nid_sos), .nid_eos(nid_eos), .nid_num(nid_num), .nid_ids(nid_ids),
    .bus_grant(bus_grant), .cur_replay_iter(cur_replay_iter), .wb_grant(wb_grant),
    .bus_req(bus_req), .bus_req_pkt(bus_req_pkt), .pe_idle(pe_idle), .task_done(task_done),
    .wb_req(wb_req), .bank_valid(bank_valid), .bank_node(bank_node), .bank_beat(bank_beat),
    .bank_iter(bank_iter), .bank_data(bank_data));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_idle"}, pe_idle, 1);
    chk({tag, "_bus_req"}, bus_req, 0);
    chk({tag, "_wb_req"}, wb_req, 0);
    chk({tag, "_bank_valid"}, bank_valid, 0);
    chk({tag, "_done"}, task_done, 0);
  endtask

  task automatic wait_bus(input string tag, input logic [7:0] exp);
    int n = 0;
    while (bus_req !== 1'b1 && n < 20) begin tick(); n++; end
    chk({tag, "_req"}, bus_req, 1);
    chk({tag, "_pkt"}, bus_req_pkt, exp);
  endtask

  task automatic grant_bus();
    bus_grant = 1; tick(); bus_grant = 0;
    chk("req_drop", bus_req, 0);
  endtask

  function automatic int wgt(input int w);
`ifdef EDGE_WEIGHT_EN
    return w;
`else
    return 1;
`endif
  endfunction

  task automatic run_task(input int w, input int cnt, input int node, input int gdly);
    int n, len, s0, s1;
    logic [15:0] e;
    task_packet = {w[3:0], cnt[2:0], node[6:0]}; task_valid = 1; tick(); task_valid = 0;
    chk("idle_busy", pe_idle, 0);
    if (cnt > 0) begin
      wait_bus("nid", {1'b0, node[6:0]});
      repeat (gdly) begin
        task_packet = 14'h3FFF; task_valid = 1; tick(); task_valid = 0;
        chk("hold_req", bus_req, 1);
        chk("hold_pkt", bus_req_pkt, {1'b0, node[6:0]});
      end
      grant_bus();
      for (int i = 0; i < cnt; i += 2) begin
        nid_sos = (i == 0); nid_eos = (i + 2 >= cnt);
        nid_num = (i + 1 < cnt) ? 2'd2 : 2'd1;
        nid_ids = {ids[i][6:0], (i + 1 < cnt) ? ids[i+1][6:0] : 7'd0};
        tick();
      end
      nid_sos = 0; nid_eos = 0; nid_num = 0; nid_ids = '0;
      for (int k = 0; k < cnt; k++) begin
        wait_bus("fv", {1'b1, ids[k][6:0]});
        grant_bus();
        for (int b = 0; b < fv_n[k]; b++) begin
          fv_sos = (b == 0); fv_eos = (b == fv_n[k] - 1); fv_data = fv_tab[k][b];
          tick();
        end
        fv_sos = 0; fv_eos = 0; fv_data = '0;
      end
    end
    n = 0;
    while (wb_req !== 1'b1 && n < 20) begin tick(); n++; end
    chk("wb_req", wb_req, 1);
    if (cnt == 0) chk("wb_req_latency", n, 0);
    wb_grant = 1; tick(); wb_grant = 0;
    len = (cnt == 0) ? 0 : (fv_n[0] > 4 ? 4 : fv_n[0]);
    for (int b = 0; b < len; b++) begin
      s0 = 0; s1 = 0;
      for (int k = 0; k < cnt; k++)
        if (b < fv_n[k]) begin
          s0 += wgt(w) * fv_tab[k][b][7:0];
          s1 += wgt(w) * fv_tab[k][b][15:8];
        end
      e = {(s1 > 255) ? 8'hFF : s1[7:0], (s0 > 255) ? 8'hFF : s0[7:0]};
      chk("bank_valid", bank_valid, 1);
      chk("bank_beat", bank_beat, b);
      chk("bank_node", bank_node, node);
      chk("bank_iter", bank_iter, cur_replay_iter);
      chk("bank_data", bank_data, e);
      chk("done_early", task_done, 0);
      tick();
    end
    if (len == 0) begin
      chk("no_beat", bank_valid, 0);
      tick();
    end
    chk("task_done", task_done, 1);
    chk("idle_after", pe_idle, 1);
    chk("valid_after", bank_valid, 0);
    tick();
    chk("done_pulse", task_done, 0);
  endtask

  initial begin
    repeat (2) tick();
    chk_quiet("rst");
    reset = 1; tick();
    chk_quiet("post_rst");

    // basic: node 1, neighbors 3 and 5, three beats each
    ids[0] = 3; ids[1] = 5; fv_n[0] = 3; fv_n[1] = 3;
    fv_tab[0][0] = 16'h0201; fv_tab[0][1] = 16'h0403; fv_tab[0][2] = 16'h0605;
    for (int b = 0; b < 3; b++) fv_tab[1][b] = 16'h0101;
    run_task(3, 2, 1, 0);

    // saturation with single-beat (sos&eos) vectors
    ids[0] = 10; ids[1] = 11; fv_n[0] = 1; fv_n[1] = 1;
    fv_tab[0][0] = 16'hFFFF; fv_tab[1][0] = 16'hFFFF;
    run_task(15, 2, 4, 0);

    // grant latency, ignored task_valid, 3 neighbors over two ID beats, length from first neighbor
    cur_replay_iter = 2'd2;
    ids[0] = 7; ids[1] = 9; ids[2] = 11; fv_n[0] = 2; fv_n[1] = 3; fv_n[2] = 1;
    fv_tab[0][0] = 16'h0A05; fv_tab[0][1] = 16'h0302;
    fv_tab[1][0] = 16'h0104; fv_tab[1][1] = 16'h0206; fv_tab[1][2] = 16'h3030;
    fv_tab[2][0] = 16'h0708;
    run_task(2, 3, 6, 5);

    // zero neighbors
    cur_replay_iter = 2'd1;
    run_task(5, 0, 9, 0);

    // reset while waiting for neighbor IDs
    task_packet = {4'd1, 3'd2, 7'd12}; task_valid = 1; tick(); task_valid = 0;
    wait_bus("abort_nid", {1'b0, 7'd12});
    grant_bus();
    reset = 0; #1;
    chk_quiet("abort");
    tick(); reset = 1; tick();
    chk_quiet("abort_rel");

    // basic again: accumulators must start clean
    ids[0] = 3; ids[1] = 5; fv_n[0] = 3; fv_n[1] = 3;
    fv_tab[0][0] = 16'h0201; fv_tab[0][1] = 16'h0403; fv_tab[0][2] = 16'h0605;
    for (int b = 0; b < 3; b++) fv_tab[1][b] = 16'h0101;
    run_task(3, 2, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/edge_pe.md
Name: edge_pe

Overview:
- Edge processing element of the GNN aggregation array.
- Accepts an aggregation task from the dispatcher: a destination node, its neighbor count and an edge weight.
- Fetches the node's neighbor-ID list, streams each neighbor's feature vector (FV) from FV SRAM, and accumulates weighted FVs lane-wise.
- Arbitrates for the write-back path and streams the result beats to the output bank.

Parameters:
- NODE_ID_W, 7, node/neighbor ID width.
- FV_W, 8, FV element width.
- LANES, 2, FV elements per beat; neighbor IDs per neighbor beat.
- MAX_BEATS, 4, maximum FV beats per vector.
- MAX_NBR, 7, maximum neighbors per task (3-bit count).
- ACC_W, 16, accumulator width.
- REPLAY_W, 2, replay-iteration width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- task_valid  in  1  dispatcher task strobe.
- task_packet  in  14  task word: [13:10] weight, [9:7] neighbor count, [6:0] node ID.
- fv_sos, fv_eos  in  1,1  FV stream start/end flags; a beat is valid when sos, eos, or mid-stream.
- fv_data  in  16  two FV lanes: [15:8]=lane1, [7:0]=lane0.
- out_sram_data  in  16  reserved; ignored.
- nid_sos, nid_eos  in  1,1  neighbor-ID beat flags.
- nid_num  in  2  valid IDs in the current neighbor beat (1..2).
- nid_ids  in  14  neighbor IDs: [13:7]=first, [6:0]=second.
- bus_grant  in  1  SRAM bus arbiter grant.
- cur_replay_iter  in  REPLAY_W  current replay iteration.
- wb_grant  in  1  write-back grant.
- bus_req  out  1  SRAM bus request.
- bus_req_pkt  out  8  request word: [7] type (0=neighbor-ID, 1=FV), [6:0] ID.
- pe_idle  out  1  ready for a new task.
- task_done  out  1  one-cycle completion pulse to IMEM controller.
- wb_req  out  1  write-back request.
- bank_valid  out  1  bank write beat valid.
- bank_node  out  7  destination node.
- bank_beat  out  2  beat index.
- bank_iter  out  REPLAY_W  replay iteration tag.
- bank_data  out  16  result beat, saturated per lane.

Behaviour:
- Reset (async, active-low): state IDLE; all outputs 0 except pe_idle=1; accumulators, counters and the neighbor list are cleared.
- IDLE: when task_valid=1, latch weight, neighbor count and node ID. Go to REQ_NID. pe_idle=0 from the next cycle.
- Neighbor count 0: skip directly to WB_REQ; the result is all zeros.
- task_valid outside IDLE is ignored.
- REQ_NID: bus_req=1, bus_req_pkt={0,node}, held until bus_grant. bus_req drops the cycle after the grant. Then WAIT_NID.
- WAIT_NID: on each neighbor beat, store nid_num IDs in order (first ID first). After the beat with nid_eos, set k=0 and go to REQ_FV.
- REQ_FV: bus_req=1, bus_req_pkt={1,nbr[k]}, held until bus_grant. Then RECV_FV.
- RECV_FV, per valid beat b (0 at sos, incrementing):
  - acc[b][lane] += fv_lane * weight, unsigned, ACC_W wide, wrap on overflow.
  - Beats beyond MAX_BEATS are dropped.
  - The beat count of the first neighbor's stream defines the result length.
  - On eos: k++. If k < count go to REQ_FV, else go to WB_REQ.
  - sos and eos high together is a single-beat vector.
- WB_REQ: wb_req=1 until wb_grant; then WB.
- WB: one beat per cycle starting the cycle after the grant, for b = 0..len-1:
  - bank_valid=1, bank_beat=b, bank_node=node, bank_iter=cur_replay_iter.
  - bank_data lane = min(acc, 255).
- After the last beat: task_done pulses for 1 cycle; clear accumulators; go to IDLE (pe_idle=1).
- Grants while not requesting are ignored. Reset mid-operation aborts the task with no partial write-back.

Optional Feature:
- EDGE_WEIGHT_EN defined: products use the latched 4-bit weight.
- Not defined: weight bits are ignored and treated as 1 (plain sum aggregation); the multiplier logic is removed.

Test Plan:
- Reset, then idle: pe_idle=1 and all requests/valids 0. Assert reset mid-WAIT_NID: immediate return to IDLE with outputs cleared.
- Basic sum (feature off):
  - Task {0011,2,1}. Expect bus_req pkt 0x01 → grant → neighbor beat num=2 IDs {3,5}.
  - FV(3)=(1,2),(3,4),(5,6); FV(5)=(1,1)×3. Expect FV requests 0x83 then 0x85.
  - wb_req, then after wb_grant, 3 beats to node 1: data {2,3},{4,5},{6,7}, then task_done.
- Same stimulus with EDGE_WEIGHT_EN: beats {6,9},{12,15},{18,21}.
- Saturation: weight 15, FV lanes 255 from two neighbors → lane output 255.
- Grant latency: hold grant low 5 cycles → bus_req stays 1 with a stable pkt. Task_valid while busy is ignored. Count 0 → immediate wb_req, and no bank beats are written since the result length is 0.
